// File: rtl/usb_phy_pkg.sv
// usb_phy_pkg: shared FS USB PHY types and line encodings.
// {dp,dm} line levels, tx states and NRZI helper.
package usb_phy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    EOP
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam int         EOP_SE0_BITS = 2;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  function automatic logic [1:0] nrzi(
    input logic [1:0] line,
    input logic       b
  );
    if (b) return line;
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_bit_tick.sv
// usb_bit_tick: CLKS_PER_BIT divider with synchronous clear.
// bit_start marks a bit's first clock, bit_end its last.
module usb_bit_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_start,
  output logic bit_end
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  assign bit_start = !clr && (cnt_q == '0);
  assign bit_end   = !clr && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/usb_fs_tx_line.sv
// usb_fs_tx_line: FS USB tx line stage (SYNC, stuffed NRZI data, EOP).
// Define USB_TX_ABORT_EN to add tx_abort (stuff-error abort, then EOP).
module usb_fs_tx_line
  import usb_phy_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
`ifdef USB_TX_ABORT_EN
  input  logic       tx_abort,
`endif
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       usb_dp,
  output logic       usb_dm,
  output logic       usb_oe
);

  localparam int            SW        = $clog2(STUFF_LIMIT + 1);
  localparam logic [SW-1:0] STUFF_MAX = SW'(STUFF_LIMIT);
  localparam logic [2:0]    EOP_IDX   = 3'(EOP_SE0_BITS);

  tx_state_e     state_q, state_d;
  logic [1:0]    line_q, line_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    nxt_q, nxt_d;
  logic          have_q, have_d;
  logic          stf_q, stf_d;
  logic [SW-1:0] stuff_q, stuff_d;
  logic          bit_start, bit_end;
  logic          load_pt, dbit;

`ifdef USB_TX_ABORT_EN
  logic abrt_q, abrt_d;
  logic run_q, run_d;
  logic abort_go;
  assign abort_go = abrt_q ||
    (tx_abort && (state_q == SYNC || state_q == DATA));
`endif

  usb_bit_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q == IDLE),
    .bit_start(bit_start),
    .bit_end  (bit_end)
  );

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    nxt_d   = nxt_q;
    have_d  = have_q;
    stf_d   = stf_q;
    stuff_d = stuff_q;
    dbit    = 1'b0;
    load_pt = bit_start && !stf_q && idx_q == 3'd7 &&
              (state_q == SYNC || state_q == DATA);
`ifdef USB_TX_ABORT_EN
    load_pt = load_pt && !abort_go;
    abrt_d  = abort_go;
    run_d   = run_q;
`endif
    tx_ready = load_pt;
    if (load_pt) begin
      have_d = tx_valid;
      if (tx_valid) nxt_d = tx_data;
    end
    unique case (state_q)
      IDLE: begin
`ifdef USB_TX_ABORT_EN
        abrt_d = 1'b0;
        run_d  = 1'b0;
`endif
        if (tx_valid) begin
          state_d = SYNC;
          line_d  = LINE_K;
          idx_d   = '0;
          stf_d   = 1'b0;
        end
      end
      SYNC, DATA: if (bit_end) begin
`ifdef USB_TX_ABORT_EN
        if (abort_go && !run_q) begin
          state_d = DATA;
          run_d   = 1'b1;
          idx_d   = '0;
        end else if (run_q) begin
          if (idx_q == 3'd7) begin
            state_d = EOP;
            line_d  = LINE_SE0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else
`endif
        if (state_q == SYNC && idx_q != 3'd7) begin
          idx_d  = idx_q + 3'd1;
          line_d = nrzi(line_q, SYNC_BYTE[idx_d]);
        end else if (state_q == DATA && !stf_q &&
                     stuff_q == STUFF_MAX) begin
          line_d  = nrzi(line_q, 1'b0);
          stuff_d = '0;
          stf_d   = 1'b1;
        end else if (state_q == DATA && idx_q != 3'd7) begin
          idx_d   = idx_q + 3'd1;
          dbit    = shift_q[idx_d];
          line_d  = nrzi(line_q, dbit);
          stuff_d = dbit ? stuff_q + 1'b1 : '0;
          stf_d   = 1'b0;
        end else if (have_q) begin
          // SYNC ends in a 1, so the run starts at one
          state_d = DATA;
          shift_d = nxt_q;
          idx_d   = '0;
          dbit    = nxt_q[0];
          line_d  = nrzi(line_q, dbit);
          stuff_d = !dbit ? '0 :
                    (state_q == SYNC) ? SW'(2) : stuff_q + 1'b1;
          stf_d   = 1'b0;
        end else begin
          state_d = EOP;
          line_d  = LINE_SE0;
          idx_d   = '0;
        end
      end
      EOP: if (bit_end) begin
        if (idx_q == EOP_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d  = idx_q + 3'd1;
          line_d = (idx_d == EOP_IDX) ? LINE_J : LINE_SE0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= LINE_J;
      idx_q   <= '0;
      shift_q <= '0;
      nxt_q   <= '0;
      have_q  <= 1'b0;
      stf_q   <= 1'b0;
      stuff_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      nxt_q   <= nxt_d;
      have_q  <= have_d;
      stf_q   <= stf_d;
      stuff_q <= stuff_d;
    end
  end

`ifdef USB_TX_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      abrt_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      abrt_q <= abrt_d;
      run_q  <= run_d;
    end
  end
`endif

  assign {usb_dp, usb_dm} = line_q;
  assign usb_oe           = (state_q != IDLE);
  assign tx_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_usb_fs_tx_line.sv
// tb_usb_fs_tx_line: scoreboard bench for usb_fs_tx_line.
// Model builds the expected per-clock line levels from packet bytes.
module tb_usb_fs_tx_line;

  localparam int         CPB = 4;
  localparam logic [1:0] LJ  = 2'b10;
  localparam logic [1:0] LK  = 2'b01;
  localparam logic [1:0] LS  = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_busy, usb_dp, usb_dm, usb_oe;
`ifdef USB_TX_ABORT_EN
  logic       tx_abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit prev_oe = 1'b0;
  int rdy_cnt = 0;
  logic [1:0] mon_e;
  logic [1:0] exp_q[$];
  int exp_rdy_q[$];
  int acc_q[$];

  usb_fs_tx_line #(
    .CLKS_PER_BIT(CPB),
    .STUFF_LIMIT (6)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
`ifdef USB_TX_ABORT_EN
    .tx_abort(tx_abort),
`endif
    .tx_ready(tx_ready),
    .tx_busy (tx_busy),
    .usb_dp  (usb_dp),
    .usb_dm  (usb_dm),
    .usb_oe  (usb_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference: bit stream = SYNC + stuffed data, NRZI from J, then EOP.
  task automatic push_pkt(input logic [7:0] bytes[$], input int abort_bit);
    logic [7:0] sb;
    logic       b;
    logic [1:0] lvl;
    logic [1:0] lv[$];
    bit         bits[$];
    int         ones;
    sb = 8'h80;
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      bits.push_back(sb[k]);
      ones = sb[k] ? ones + 1 : 0;
    end
    foreach (bytes[n]) begin
      for (int k = 0; k < 8; k++) begin
        b = bytes[n][k];
        bits.push_back(b);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
          bits.push_back(1'b0);
          ones = 0;
        end
      end
    end
    lvl = LJ;
    foreach (bits[i]) begin
      if (!bits[i]) lvl = (lvl == LJ) ? LK : LJ;
      lv.push_back(lvl);
    end
    if (abort_bit >= 0) begin
      lvl = lv[abort_bit];
      while (lv.size() > abort_bit + 1) void'(lv.pop_back());
      repeat (8) lv.push_back(lvl);
    end
    lv.push_back(LS);
    lv.push_back(LS);
    lv.push_back(LJ);
    foreach (lv[i]) repeat (CPB) exp_q.push_back(lv[i]);
  endtask

  task automatic send_pkt(input logic [7:0] bytes[$]);
    int n;
    push_pkt(bytes, -1);
    exp_rdy_q.push_back(bytes.size());
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = bytes[0];
    foreach (bytes[i]) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!tx_ready && n < 400);
      chk("ready_seen", tx_ready, 1'b1);
      acc_q.push_back(cyc);
      @(posedge clk);
      #1;
      if (i + 1 < bytes.size()) tx_data = bytes[i+1];
      else tx_valid = 1'b0;
    end
    tx_valid = 1'b0;
    n = 0;
    while (tx_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("pkt_done", tx_busy, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      rdy_cnt = 0;
      prev_oe = 1'b0;
    end else begin
      if (tx_ready && tx_valid) rdy_cnt++;
      if (usb_oe) begin
        if (exp_q.size() == 0) begin
          chk("oe_len_long", usb_oe, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("line", {usb_dp, usb_dm}, mon_e);
          chk("busy", tx_busy, 1'b1);
        end
      end else begin
        chk("idle_line", {usb_dp, usb_dm}, LJ);
        chk("idle_ready", tx_ready, 1'b0);
        if (prev_oe) begin
          chk("oe_len_short", exp_q.size(), 0);
          chk("xfers", rdy_cnt,
              exp_rdy_q.size() > 0 ? exp_rdy_q.pop_front() : -1);
          rdy_cnt = 0;
        end
      end
      prev_oe = usb_oe;
    end
  end

  initial begin
    logic [7:0] pk[$];
    int gap;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_dp", usb_dp, 1'b1);
      chk("rst_dm", usb_dm, 1'b0);
      chk("rst_oe", usb_oe, 1'b0);
      chk("rst_ready", tx_ready, 1'b0);
      chk("rst_busy", tx_busy, 1'b0);
    end
    mon_en = 1'b1;

    pk = '{8'hD2};
    send_pkt(pk);
    pk = '{8'hFF};
    send_pkt(pk);
    acc_q.delete();
    pk = '{8'h00, 8'h01};
    send_pkt(pk);
    gap = (acc_q.size() >= 2) ? acc_q[1] - acc_q[0] : -1;
    chk("ready_gap", gap, 32);

    for (int p = 0; p < 8; p++) begin
      pk.delete();
      for (int i = 0; i < $urandom_range(1, 4); i++)
        pk.push_back($urandom_range(0, 1) ? 8'hFF : 8'($urandom));
      send_pkt(pk);
    end

    mon_en = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    repeat (42) @(negedge clk);
    chk("rst_mid_pre_oe", usb_oe, 1'b1);
    rst = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_dp", usb_dp, 1'b1);
    chk("rst_mid_dm", usb_dm, 1'b0);
    chk("rst_mid_oe", usb_oe, 1'b0);
    chk("rst_mid_busy", tx_busy, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_rdy_q.delete();
    mon_en = 1'b1;
    pk = '{8'hD2};
    send_pkt(pk);

`ifdef USB_TX_ABORT_EN
    pk = '{8'h00, 8'h00};
    push_pkt(pk, 18);
    exp_rdy_q.push_back(2);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      tx_abort = (c == 73);
      if (c > 80 && !tx_busy) break;
    end
    tx_valid = 1'b0;
    tx_abort = 1'b0;
    chk("abort_done", tx_busy, 1'b0);
    repeat (3) @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    chk("sb_rdy_drain", exp_rdy_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
